// File: rtl/fir_pkg.sv
// Shared sizing and arithmetic helpers for the configurable N-tap FIR filter.
// Helpers work on 64-bit signed values; callers size-cast to their own widths.
package fir_pkg;

  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Half-LSB offset added before the arithmetic shift (round-half-up).
  function automatic logic signed [63:0] round_const(input int unsigned shift);
    return (shift == 0) ? 64'sd0 : (64'sd1 <<< (shift - 1));
  endfunction

  function automatic logic [63:0] approx_mask(input int unsigned lsb);
    return ~((64'd1 << lsb) - 64'd1);
  endfunction

  function automatic logic signed [63:0] sat_clip(input  logic signed [63:0] r,
                                                  input  int unsigned        dw,
                                                  output logic               ovf);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    ovf = 1'b0;
    sat_clip = r;
    if (r > hi) begin
      sat_clip = hi;
      ovf      = 1'b1;
    end else if (r < lo) begin
      sat_clip = lo;
      ovf      = 1'b1;
    end
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: identity reset (c[0] = 1.0), synchronous write,
// out-of-range writes dropped, all taps presented on one flat bus.
module fir_coef_bank #(
  parameter int COEF_W    = 16,
  parameter int TAPS      = 3,
  parameter int OUT_SHIFT = 14
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  output logic [TAPS*COEF_W-1:0]     coef_bus
);

  localparam logic [COEF_W-1:0] C0_ID = COEF_W'(1) << OUT_SHIFT;

  logic [COEF_W-1:0] c [TAPS];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        c[k] <= (k == 0) ? C0_ID : '0;
      end
    end else if (coef_we && (int'(coef_addr) < TAPS)) begin
      c[coef_addr] <= coef_data;
    end
  end

  always_comb begin
    coef_bus = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      coef_bus[k*COEF_W +: COEF_W] = c[k];
    end
  end

endmodule

// File: rtl/fir_ntap_cfg.sv
// Parametrised direct-form FIR: multiply stage, sum stage, round/saturate
// output register. Valid-qualified with bubbles; coefficients loadable at run time.
module fir_ntap_cfg
  import fir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int TAPS       = 3,
  parameter int OUT_SHIFT  = 14,
  parameter int APPROX_LSB = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     approx_en,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat_flag
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam logic signed [63:0]  RND  = round_const(OUT_SHIFT);
  localparam logic [PROD_W-1:0]   MASK = PROD_W'(approx_mask(APPROX_LSB));

  logic [TAPS*COEF_W-1:0]    coef_bus;
  logic signed [DATA_W-1:0]  dly    [TAPS-1];
  logic signed [DATA_W-1:0]  xtap   [TAPS];
  logic signed [COEF_W-1:0]  cf     [TAPS];
  logic signed [PROD_W-1:0]  prod_m [TAPS];
  logic signed [PROD_W-1:0]  p      [TAPS];
  logic                      v1;
  logic                      v2;
  logic signed [ACC_W-1:0]   acc_c;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [63:0]        acc_ext;
  logic signed [63:0]        rnd_sh;
  logic signed [63:0]        clip64;
  logic signed [DATA_W-1:0]  y_c;
  logic                      ovf_c;

  // A write in the same cycle as an accepted sample lands after the multiply
  // has already used the old coefficient, since both read the registered bank.
  fir_coef_bank #(
    .COEF_W    (COEF_W),
    .TAPS      (TAPS),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_coef_bank (
    .clk       (clk),
    .rstN      (rstN),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_bus  (coef_bus)
  );

  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      xtap[k]   = (k == 0) ? x : dly[k-1];
      cf[k]     = coef_bus[k*COEF_W +: COEF_W];
      prod_m[k] = PROD_W'(xtap[k]) * PROD_W'(cf[k]);
      if (approx_en) begin
        prod_m[k] = prod_m[k] & MASK;
      end
    end
  end

  always_comb begin
    acc_c = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      acc_c = acc_c + ACC_W'(p[k]);
    end
  end

  always_comb begin
    acc_ext = 64'(acc_q);
    rnd_sh  = (acc_ext + RND) >>> OUT_SHIFT;
    ovf_c   = 1'b0;
    clip64  = sat_clip(rnd_sh, DATA_W, ovf_c);
    y_c     = DATA_W'(clip64);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int unsigned k = 0; k < TAPS - 1; k++) begin
        dly[k] <= '0;
      end
      for (int unsigned k = 0; k < TAPS; k++) begin
        p[k] <= '0;
      end
      v1        <= 1'b0;
      v2        <= 1'b0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      sat_flag  <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        dly[0] <= x;
        for (int unsigned k = 1; k < TAPS - 1; k++) begin
          dly[k] <= dly[k-1];
        end
        for (int unsigned k = 0; k < TAPS; k++) begin
          p[k] <= prod_m[k];
        end
      end
      v2 <= v1;
      if (v1) begin
        acc_q <= acc_c;
      end
      out_valid <= v2;
      if (v2) begin
        y        <= y_c;
        sat_flag <= ovf_c;
      end
    end
  end

endmodule
